// File: rtl/seq_pattern_det.sv
// Serial pattern detector: shifts qualified input bits into a PAT_W-bit history,
// flags matches against a pattern latched on clear, and keeps a saturating match count.
module seq_pattern_det #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_mode_overlap,
    input  logic             i_in_valid,
    input  logic             i_in,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_cnt_sat,
    output logic [PAT_W-1:0] o_hist,
    output logic             o_busy
);

    localparam int FC_W = $clog2(PAT_W);
    localparam logic [FC_W-1:0]  FILL_LAST = FC_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_hist;
    logic [PAT_W-1:0] r_pattern;
    logic [FC_W-1:0]  r_fill_cnt;
    logic             r_match;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_cnt_sat;
    logic             r_busy;

    state_t           w_state_next;
    logic [PAT_W-1:0] w_hist_next;
    logic [PAT_W-1:0] w_pattern_next;
    logic [FC_W-1:0]  w_fill_next;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;
    logic [PAT_W-1:0] w_hist_shift;
    logic             w_cmp;

    assign w_hist_shift = {r_hist[PAT_W-2:0], i_in};
    assign w_cmp        = (w_hist_shift == r_pattern);

    // Next-state, history, fill counter and match decision.
    always_comb begin
        w_state_next   = r_state;
        w_hist_next    = r_hist;
        w_pattern_next = r_pattern;
        w_fill_next    = r_fill_cnt;
        w_hit          = 1'b0;
        if (i_clr) begin
            w_pattern_next = i_pattern;
            w_hist_next    = {PAT_W{1'b0}};
            w_fill_next    = {FC_W{1'b0}};
            w_state_next   = ST_FILL;
        end else if (i_in_valid) begin
            case (r_state)
                ST_FILL: begin
                    w_hist_next = w_hist_shift;
                    if (r_fill_cnt == FILL_LAST) begin
                        // Window just became full: this beat may already match.
                        w_hit       = w_cmp;
                        w_fill_next = {FC_W{1'b0}};
                        if (w_cmp && !i_mode_overlap) begin
                            w_state_next = ST_FILL;
                        end else begin
                            w_state_next = ST_RUN;
                        end
                    end else begin
                        w_fill_next = r_fill_cnt + FC_W'(1);
                    end
                end
                ST_RUN: begin
                    w_hist_next = w_hist_shift;
                    w_hit       = w_cmp;
                    if (w_cmp && !i_mode_overlap) begin
                        w_fill_next  = {FC_W{1'b0}};
                        w_state_next = ST_FILL;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Saturating match counter with sticky saturation flag.
    always_comb begin
        w_cnt_next = r_match_cnt;
        w_sat_next = r_cnt_sat;
        if (i_clr) begin
            w_cnt_next = {CNT_W{1'b0}};
            w_sat_next = 1'b0;
        end else if (w_hit) begin
            if (r_match_cnt != CNT_MAX) begin
                w_cnt_next = r_match_cnt + CNT_W'(1);
            end else begin
                w_cnt_next = r_match_cnt;
            end
            if (r_match_cnt == CNT_PRE) begin
                w_sat_next = 1'b1;
            end else begin
                w_sat_next = r_cnt_sat;
            end
        end else begin
            w_cnt_next = r_match_cnt;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_hist      <= {PAT_W{1'b0}};
            r_pattern   <= {PAT_W{1'b0}};
            r_fill_cnt  <= {FC_W{1'b0}};
            r_match     <= 1'b0;
            r_match_cnt <= {CNT_W{1'b0}};
            r_cnt_sat   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hist      <= w_hist_next;
            r_pattern   <= w_pattern_next;
            r_fill_cnt  <= w_fill_next;
            r_match     <= w_hit;
            r_match_cnt <= w_cnt_next;
            r_cnt_sat   <= w_sat_next;
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    assign o_match     = r_match;
    assign o_match_cnt = r_match_cnt;
    assign o_cnt_sat   = r_cnt_sat;
    assign o_hist      = r_hist;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_seq_pattern_det.sv
// Randomized and directed bench for seq_pattern_det against a stream-based reference model.
module tb_seq_pattern_det;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             clr;
    logic [PAT_W-1:0] pattern;
    logic             mode_overlap;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic [PAT_W-1:0] hist;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: raw bit stream since clear, beats since last window restart.
    bit m_active;
    int m_pattern;
    bit m_stream[$];
    int m_win;
    int m_cnt;
    bit m_sat;
    bit m_match;

    seq_pattern_det #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clr          (clr),
        .i_pattern      (pattern),
        .i_mode_overlap (mode_overlap),
        .i_in_valid     (in_valid),
        .i_in           (in_bit),
        .o_match        (match),
        .o_match_cnt    (match_cnt),
        .o_cnt_sat      (cnt_sat),
        .o_hist         (hist),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_hist();
        int v = 0;
        for (int k = 0; k < m_stream.size(); k++) v = v * 2 + int'(m_stream[k]);
        return v;
    endfunction

    task automatic model_update(input bit r, input bit c, input bit v, input bit b);
        m_match = 1'b0;
        if (!r) begin
            m_active = 1'b0; m_pattern = 0; m_stream.delete(); m_win = 0; m_cnt = 0; m_sat = 1'b0;
        end else if (c) begin
            m_active = 1'b1; m_pattern = int'(pattern); m_stream.delete(); m_win = 0; m_cnt = 0; m_sat = 1'b0;
        end else if (m_active && v) begin
            m_stream.push_back(b);
            if (m_stream.size() > PAT_W) void'(m_stream.pop_front());
            m_win++;
            if (m_win >= PAT_W && model_hist() == m_pattern) begin
                m_match = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_cnt == CNT_MAX) m_sat = 1'b1;
                if (!mode_overlap) m_win = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input bit b);
        @(negedge clk);
        rst = r; clr = c; in_valid = v; in_bit = b;
        @(posedge clk);
        #1;
        model_update(r, c, v, b);
        check_val("match", int'(match), int'(m_match));
        check_val("match_cnt", int'(match_cnt), m_cnt);
        check_val("cnt_sat", int'(cnt_sat), int'(m_sat));
        check_val("hist", int'(hist), model_hist());
        check_val("busy", int'(busy), int'(m_active));
    endtask

    task automatic beats(input logic [15:0] bits, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b1, bits[i]);
            if (gaps) step(1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        pattern = '0; mode_overlap = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("reset_busy", int'(busy), 0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check_val("idle_hist", int'(hist), 0);

        // Overlapping detection.
        pattern = 4'b1011; mode_overlap = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        beats(16'b1011011, 7, 1'b0);
        check_val("t1_cnt", int'(match_cnt), 2);
        check_val("t1_hist", int'(hist), 11);

        // Non-overlapping detection.
        mode_overlap = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        beats(16'b1011011, 7, 1'b0);
        check_val("t2_cnt", int'(match_cnt), 1);

        // Gapped stream.
        mode_overlap = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        beats(16'b1011011, 7, 1'b1);
        check_val("t3_cnt", int'(match_cnt), 2);

        // Saturation.
        pattern = 4'b0000;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        beats(16'b0, 10, 1'b0);
        check_val("t4_cnt", int'(match_cnt), 3);
        check_val("t4_sat", int'(cnt_sat), 1);

        // Clear colliding with a valid beat, then new pattern.
        pattern = 4'b1011;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        beats(16'b101, 3, 1'b0);
        pattern = 4'b0110;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("t5_hist", int'(hist), 0);
        beats(16'b0110, 4, 1'b0);
        check_val("t5_cnt", int'(match_cnt), 1);

        // Reset mid-run, beats ignored afterwards.
        pattern = 4'b1011;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        beats(16'b1011011, 7, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("t6_busy", int'(busy), 0);
        beats(16'b1011, 4, 1'b0);
        check_val("t6_cnt", int'(match_cnt), 0);

        // Random traffic with occasional clear/reset and live mode changes.
        for (int i = 0; i < 4000; i++) begin
            bit r, c;
            mode_overlap = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 199) != 0);
            c = ($urandom_range(0, 39) == 0);
            if (c) pattern = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
            step(r, c, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
